// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared constants, FSM states and weight tag type for the layer scheduler
package nn_pkg;

  localparam int N_UNITS  = 4;
  localparam int N_INPUTS = 4;
  localparam int N_LAYERS = 3;
  localparam int UNIT_W   = $clog2(N_UNITS);
  localparam int INPUT_W  = $clog2(N_INPUTS);
  localparam int ENTRY_W  = UNIT_W + INPUT_W;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    DRAIN,
    SUM,
    WAIT_DONE
  } state_t;

  // Travels alongside an outstanding RAM read so the returning byte can be steered.
  typedef struct packed {
    logic               valid;
    logic [UNIT_W-1:0]  unit;
    logic [INPUT_W-1:0] input_idx;
  } weight_tag_t;

  // First weight RAM entry of a layer: each layer owns N_UNITS*N_INPUTS consecutive words.
  function automatic logic [31:0] layer_base(input logic [1:0] layer);
    return 32'(layer) * 32'(N_UNITS * N_INPUTS);
  endfunction

endpackage

// File: rtl/weight_tag_pipe.sv
// rtl/weight_tag_pipe.sv - fixed-depth delay line that aligns weight tags with RAM read data
module weight_tag_pipe
  import nn_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        flush,
  input  weight_tag_t tag_in,
  output weight_tag_t tag_out,
  output logic        pending
);

  weight_tag_t stage [DEPTH];

  // Shift tags one stage per cycle; flush drops every in-flight tag.
  always_ff @(posedge clk) begin
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

  // Any valid tag still inside the line means a strobe is yet to come.
  always_comb begin
    pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) pending = pending | stage[i].valid;
  end

endmodule

// File: rtl/layer_weight_scheduler.sv
// rtl/layer_weight_scheduler.sv - walks one layer of weight RAM into the neural units, then triggers summation
module layer_weight_scheduler
  import nn_pkg::*;
#(
  parameter int ADDR_W  = 10,
  parameter int RAM_LAT = 2,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         layer,
  output logic [ADDR_W-1:0]  ram_addr,
  input  logic [31:0]        ram_rdata,
  output logic [7:0]         weight_data,
  output logic [1:0]         weight_addr,
  output logic [N_UNITS-1:0] weight_we,
  output logic               sum_trigger,
  input  logic [N_UNITS-1:0] unit_done,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam int LAST_K = N_UNITS * N_INPUTS - 1;
  localparam int CNT_W  = $clog2(TIMEOUT + 1);

  state_t             state, state_n;
  logic [ENTRY_W-1:0] k;
  logic [CNT_W-1:0]   wait_cnt;
  weight_tag_t        tag_in, tag_out;
  logic               pending;
  logic               accept, layer_ok, all_done, timeout_hit, last_k;
  logic               unused_rdata;

  // Only the low byte of each RAM word carries a weight.
  assign unused_rdata = ^ram_rdata[31:8];

  // A start coinciding with the done pulse is dropped so the controller must re-request.
  assign accept      = (state == IDLE) && start && !done;
  assign layer_ok    = 32'(layer) < 32'(N_LAYERS);
  assign all_done    = &unit_done;
  assign timeout_hit = (wait_cnt == CNT_W'(TIMEOUT - 1));
  assign last_k      = (k == ENTRY_W'(LAST_K));

  // Tag for the address currently on ram_addr; k splits into unit (high bits) and input (low bits).
  always_comb begin
    tag_in           = '0;
    tag_in.valid     = (state == ISSUE);
    tag_in.unit      = k[ENTRY_W-1:INPUT_W];
    tag_in.input_idx = k[INPUT_W-1:0];
  end

  weight_tag_pipe #(
    .DEPTH (RAM_LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .flush   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out),
    .pending (pending)
  );

  // Next-state and Moore outputs; SUM waits for a fully empty tag line so the last weight lands first.
  always_comb begin
    state_n     = state;
    busy        = (state != IDLE);
    sum_trigger = (state == SUM);
    case (state)
      IDLE:      if (accept && layer_ok) state_n = ISSUE;
      ISSUE:     if (last_k) state_n = DRAIN;
      DRAIN:     if (!pending) state_n = SUM;
      SUM:       state_n = WAIT_DONE;
      WAIT_DONE: if (all_done || timeout_hit) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // State register, address walk, done-wait timer and the done/err flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      k        <= '0;
      wait_cnt <= '0;
      ram_addr <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state <= state_n;
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            err <= !layer_ok;
            k   <= '0;
            if (layer_ok) ram_addr <= ADDR_W'(layer_base(layer));
          end
        end
        ISSUE: begin
          k <= k + ENTRY_W'(1);
          if (!last_k) ram_addr <= ram_addr + ADDR_W'(1);
        end
        SUM: wait_cnt <= '0;
        WAIT_DONE: begin
          wait_cnt <= wait_cnt + CNT_W'(1);
          if (all_done) done <= 1'b1;
          else if (timeout_hit) err <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Return path: register the RAM byte and strobe the unit named by the tag leaving the line.
  always_ff @(posedge clk) begin
    if (reset) begin
      weight_data <= '0;
      weight_addr <= '0;
      weight_we   <= '0;
    end else begin
      weight_we <= '0;
      if (tag_out.valid) begin
        weight_data              <= ram_rdata[7:0];
        weight_addr              <= tag_out.input_idx;
        weight_we[tag_out.unit]  <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_layer_weight_scheduler.sv
// tb/tb_layer_weight_scheduler.sv - self-checking bench for layer_weight_scheduler
module tb_layer_weight_scheduler;

  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 20;

  logic clk = 1'b0;
  logic reset, start;
  logic [1:0] layer;
  logic [3:0] unit_done;

  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_rdata;
  logic [7:0]        weight_data;
  logic [1:0]        weight_addr;
  logic [3:0]        weight_we;
  logic              sum_trigger, busy, done, err;

  logic [ADDR_W-1:0] l1_ram_addr, l4_ram_addr;
  logic [31:0]       l1_ram_rdata, l4_ram_rdata;
  logic [7:0]        l1_weight_data, l4_weight_data;
  logic [1:0]        l1_unused_waddr, l4_unused_waddr;
  logic [3:0]        l1_weight_we, l4_weight_we;
  logic              l1_unused_sum, l4_unused_sum, l1_unused_err, l4_unused_err;
  logic              l1_busy, l4_busy, l1_done, l4_done;

  layer_weight_scheduler #(.ADDR_W(ADDR_W), .RAM_LAT(2), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .layer(layer),
    .ram_addr(ram_addr), .ram_rdata(ram_rdata),
    .weight_data(weight_data), .weight_addr(weight_addr), .weight_we(weight_we),
    .sum_trigger(sum_trigger), .unit_done(unit_done),
    .busy(busy), .done(done), .err(err)
  );

  layer_weight_scheduler #(.ADDR_W(ADDR_W), .RAM_LAT(1), .TIMEOUT(TIMEOUT)) u_lat1 (
    .clk(clk), .reset(reset), .start(start), .layer(layer),
    .ram_addr(l1_ram_addr), .ram_rdata(l1_ram_rdata),
    .weight_data(l1_weight_data), .weight_addr(l1_unused_waddr), .weight_we(l1_weight_we),
    .sum_trigger(l1_unused_sum), .unit_done(unit_done),
    .busy(l1_busy), .done(l1_done), .err(l1_unused_err)
  );

  layer_weight_scheduler #(.ADDR_W(ADDR_W), .RAM_LAT(4), .TIMEOUT(TIMEOUT)) u_lat4 (
    .clk(clk), .reset(reset), .start(start), .layer(layer),
    .ram_addr(l4_ram_addr), .ram_rdata(l4_ram_rdata),
    .weight_data(l4_weight_data), .weight_addr(l4_unused_waddr), .weight_we(l4_weight_we),
    .sum_trigger(l4_unused_sum), .unit_done(unit_done),
    .busy(l4_busy), .done(l4_done), .err(l4_unused_err)
  );

  always #5 clk = ~clk;

  // RAM models with mem[a] = a and the matching read latency per instance.
  logic [ADDR_W-1:0] m1 [1];
  logic [ADDR_W-1:0] m2 [2];
  logic [ADDR_W-1:0] m4 [4];
  always @(posedge clk) begin
    m1[0] <= l1_ram_addr;
    m2[0] <= ram_addr;
    m2[1] <= m2[0];
    m4[0] <= l4_ram_addr;
    for (int i = 1; i < 4; i++) m4[i] <= m4[i-1];
  end
  assign l1_ram_rdata = {22'd0, m1[0]};
  assign ram_rdata    = {22'd0, m2[1]};
  assign l4_ram_rdata = {22'd0, m4[3]};

  int checks = 0;
  int errors = 0;
  int strobe_cnt = 0;
  bit mon_en = 1'b0;
  logic [13:0] sb_q [$];
  logic [13:0] mon_exp;

  int fb1, fw1, n1, d1, fb4, fw4, n4, d4;
  logic [7:0] fd1, fd4;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic push_pass(input int lay);
    for (int e = 0; e < 16; e++)
      sb_q.push_back({4'(1 << (e / 4)), 2'(e % 4), 8'(lay * 16 + e)});
  endtask

  // Scoreboard: every strobe of the main instance must match the next expected entry.
  always @(negedge clk) begin
    if (mon_en && weight_we !== 4'd0) begin
      strobe_cnt++;
      checks++;
      assert (sb_q.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_strobe: observed we=%b expected no strobe", weight_we);
      end
      if (sb_q.size() != 0) begin
        mon_exp = sb_q.pop_front();
        chk("strobe_we_addr_data", {18'd0, weight_we, weight_addr, weight_data}, {18'd0, mon_exp});
      end
    end
  end

  // Launch a pass and check the 16 addresses, strobe window and sum pulse; ends on the SUM cycle.
  task automatic run_pass(input int lay, input bit poke);
    strobe_cnt = 0;
    push_pass(lay);
    start = 1'b1;
    layer = 2'(lay);
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 20; j++) begin
      if (j == 0) chk("err_cleared_on_start", {31'd0, err}, 32'd0);
      if (j < 16) chk($sformatf("ram_addr_j%0d", j), {22'd0, ram_addr}, 32'(lay * 16 + j));
      chk($sformatf("we_window_j%0d", j), {31'd0, weight_we != 4'd0}, {31'd0, (j >= 3 && j <= 18)});
      chk($sformatf("sum_trigger_j%0d", j), {31'd0, sum_trigger}, {31'd0, j == 19});
      chk($sformatf("busy_j%0d", j), {31'd0, busy}, 32'd1);
      if (poke) begin
        start = (j == 4 || j == 8 || j == 12);
        layer = 2'd2;
      end
      if (j < 19) @(negedge clk);
    end
    chk("strobe_count", strobe_cnt, 32'd16);
    chk("scoreboard_empty", sb_q.size(), 32'd0);
  endtask

  // From the SUM cycle: all units done at once; optionally assert start on the done cycle.
  task automatic finish_fast(input bit poke_start);
    unit_done = 4'hF;
    @(negedge clk);
    chk("fast_done_w1", {31'd0, done}, 32'd0);
    chk("fast_busy_w1", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("fast_done_w2", {31'd0, done}, 32'd1);
    chk("fast_busy_w2", {31'd0, busy}, 32'd0);
    unit_done = 4'h0;
    if (poke_start) begin
      start = 1'b1;
      layer = 2'd0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("start_on_done_ignored", {31'd0, busy}, 32'd0);
    chk("done_single_pulse", {31'd0, done}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    layer = 2'd0;
    unit_done = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("rst_weight_data", {24'd0, weight_data}, 32'd0);
    chk("rst_weight_addr", {30'd0, weight_addr}, 32'd0);
    chk("rst_weight_we", {28'd0, weight_we}, 32'd0);
    chk("rst_sum_trigger", {31'd0, sum_trigger}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    mon_en = 1'b1;
    reset = 1'b0;
    @(negedge clk);

    // Layer 1 pass, units finish one by one.
    run_pass(1, 1'b0);
    for (int w = 1; w <= 16; w++) begin
      @(negedge clk);
      chk($sformatf("staggered_done_w%0d", w), {31'd0, done}, {31'd0, w == 13});
      chk($sformatf("staggered_busy_w%0d", w), {31'd0, busy}, {31'd0, w < 13});
      unit_done = {w >= 12, w >= 9, w >= 7, w >= 5};
    end
    unit_done = 4'd0;

    // Out-of-range layer.
    start = 1'b1;
    layer = 2'd3;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk($sformatf("bad_layer_err_c%0d", c), {31'd0, err}, 32'd1);
      chk($sformatf("bad_layer_busy_c%0d", c), {31'd0, busy}, 32'd0);
      chk($sformatf("bad_layer_addr_c%0d", c), {22'd0, ram_addr}, 32'd31);
      chk($sformatf("bad_layer_done_c%0d", c), {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Layer 0 with start re-pulsed mid-pass, then start on the done cycle.
    run_pass(0, 1'b1);
    finish_fast(1'b1);
    chk("addr_after_ignored_start", {22'd0, ram_addr}, 32'd15);

    // Reset on the 8th issue cycle.
    strobe_cnt = 0;
    push_pass(2);
    start = 1'b1;
    layer = 2'd2;
    @(negedge clk);
    start = 1'b0;
    for (int j = 0; j < 8; j++) begin
      chk($sformatf("abort_addr_j%0d", j), {22'd0, ram_addr}, 32'(32 + j));
      if (j == 7) reset = 1'b1;
      @(negedge clk);
    end
    chk("abort_ram_addr", {22'd0, ram_addr}, 32'd0);
    chk("abort_weight_we", {28'd0, weight_we}, 32'd0);
    chk("abort_weight_data", {24'd0, weight_data}, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_strobes_before_reset", strobe_cnt, 32'd5);
    sb_q.delete();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      chk($sformatf("post_abort_we_c%0d", c), {28'd0, weight_we}, 32'd0);
      chk($sformatf("post_abort_busy_c%0d", c), {31'd0, busy}, 32'd0);
    end
    run_pass(2, 1'b0);
    finish_fast(1'b0);

    // Timeout with one unit never finishing.
    run_pass(0, 1'b0);
    unit_done = 4'b0111;
    for (int w = 1; w <= 22; w++) begin
      @(negedge clk);
      chk($sformatf("timeout_done_w%0d", w), {31'd0, done}, 32'd0);
      chk($sformatf("timeout_err_w%0d", w), {31'd0, err}, {31'd0, w >= 21});
      chk($sformatf("timeout_busy_w%0d", w), {31'd0, busy}, {31'd0, w <= 20});
    end
    unit_done = 4'd0;

    // Latency sweep: all three instances run layer 2 from a common reset.
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    strobe_cnt = 0;
    push_pass(2);
    unit_done = 4'hF;
    start = 1'b1;
    layer = 2'd2;
    @(negedge clk);
    start = 1'b0;
    fb1 = -1; fw1 = -1; n1 = 0; d1 = 0; fd1 = 8'd0;
    fb4 = -1; fw4 = -1; n4 = 0; d4 = 0; fd4 = 8'd0;
    for (int c = 0; c < 40; c++) begin
      if (l1_busy && fb1 < 0) fb1 = c;
      if (l1_weight_we != 4'd0) begin
        n1++;
        if (fw1 < 0) begin fw1 = c; fd1 = l1_weight_data; end
      end
      if (l1_done) d1++;
      if (l4_busy && fb4 < 0) fb4 = c;
      if (l4_weight_we != 4'd0) begin
        n4++;
        if (fw4 < 0) begin fw4 = c; fd4 = l4_weight_data; end
      end
      if (l4_done) d4++;
      @(negedge clk);
    end
    unit_done = 4'd0;
    chk("lat1_first_addr_cycle", fb1, 32'd0);
    chk("lat1_strobe_offset", fw1 - fb1, 32'd2);
    chk("lat1_strobe_count", n1, 32'd16);
    chk("lat1_first_data", {24'd0, fd1}, 32'd32);
    chk("lat1_done_pulses", d1, 32'd1);
    chk("lat1_idle_at_end", {31'd0, l1_busy}, 32'd0);
    chk("lat4_first_addr_cycle", fb4, 32'd0);
    chk("lat4_strobe_offset", fw4 - fb4, 32'd5);
    chk("lat4_strobe_count", n4, 32'd16);
    chk("lat4_first_data", {24'd0, fd4}, 32'd32);
    chk("lat4_done_pulses", d4, 32'd1);
    chk("lat4_idle_at_end", {31'd0, l4_busy}, 32'd0);
    chk("lat2_strobe_count", strobe_cnt, 32'd16);
    chk("lat2_scoreboard_empty", sb_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
